// File: rtl/biu_constants_pkg.sv
// Shared AHB3-Lite encodings used by the bus interface units.
package biu_constants_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_INCR   = 3'b001;

    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HSIZE_DWORD   = 3'b011;

    // An incrementing burst may not cross a 1 KB boundary, so such an address restarts with NONSEQ.
    function automatic logic at_1k_boundary(input logic [9:0] low_bits);
        return low_bits == 10'h000;
    endfunction

endpackage

// File: rtl/riscv_iprefetch_fifo.sv
// Small power-of-two FIFO holding prefetched parcels; clear wins over push and pop.
module riscv_iprefetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         push_data,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Qualify requests against the current fill state.
    always_comb begin
        do_push_s = push && !full;
        do_pop_s  = pop && !empty;
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else if (clear) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage.
    always_ff @(posedge clk) begin
        if (do_push_s && !clear) mem_r[wr_ptr_r] <= push_data;
    end

    assign pop_data  = mem_r[rd_ptr_r];
    assign full      = (count_r == (AW+1)'(DEPTH));
    assign empty     = (count_r == (AW+1)'(0));
    assign occupancy = count_r;

endmodule

// File: rtl/riscv_iprefetch_ahb3lite.sv
// Instruction prefetcher: sequential AHB3-Lite word fetches into a small parcel FIFO,
// with redirect (flush), bus-error and misaligned-target handling.
module riscv_iprefetch_ahb3lite
    import biu_constants_pkg::*;
#(
    parameter int               XLEN           = 32,
    parameter int               PHYS_ADDR_SIZE = XLEN,
    parameter int               PARCEL_SIZE    = XLEN,
    parameter int               DEPTH          = 4,
    parameter logic [XLEN-1:0]  PC_INIT        = 32'h0000_0200
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    output logic                      HSEL,
    output logic [PHYS_ADDR_SIZE-1:0] HADDR,
    input  logic [XLEN-1:0]           HRDATA,
    output logic [XLEN-1:0]           HWDATA,
    output logic                      HWRITE,
    output logic [2:0]                HSIZE,
    output logic [2:0]                HBURST,
    output logic [3:0]                HPROT,
    output logic [1:0]                HTRANS,
    output logic                      HMASTLOCK,
    input  logic                      HREADY,
    input  logic                      HRESP,
    input  logic [XLEN-1:0]           if_nxt_pc,
    input  logic                      if_flush,
    input  logic                      if_stall,
    input  logic [1:0]                st_prv,
    output logic [PARCEL_SIZE-1:0]    if_parcel,
    output logic [XLEN-1:0]           if_parcel_pc,
    output logic                      if_parcel_valid,
    output logic                      if_parcel_misaligned,
    output logic                      if_parcel_error,
    output logic                      if_stall_nxt_pc
);

    localparam int OFFS    = $clog2(XLEN/8);
    localparam int ENTRY_W = PARCEL_SIZE + XLEN + 2;
    localparam int OCC_W   = $clog2(DEPTH) + 1;
    localparam int BUD_W   = OCC_W + 1;

    logic [PHYS_ADDR_SIZE-1:0] haddr_r, haddr_n, fetch_adr_r, fetch_adr_n, flush_adr_s;
    logic [1:0]                htrans_r, htrans_n, htrans_s;
    logic                      need_nonseq_r, need_nonseq_n, addr_stale_r, addr_stale_n;
    logic                      dphase_valid_r, dphase_valid_n, dphase_stale_r, dphase_stale_n;
    logic [XLEN-1:0]           dphase_pc_r, dphase_pc_n, mis_pc_r, mis_pc_n;
    logic                      halt_r, halt_n, mis_pend_r, mis_pend_n;
    logic                      addr_busy_s, err_first_s, can_issue_s, push_bus_s, misaligned_s;
    logic [BUD_W-1:0]          budget_s;
    logic [OCC_W-1:0]          occupancy_s;
    logic                      full_s, empty_s, pop_s;
    logic [ENTRY_W-1:0]        push_data_s, head_s;

    // Bus status and issue budget (buffered + in flight + the new one must fit).
    always_comb begin
        addr_busy_s  = (htrans_r != HTRANS_IDLE);
        err_first_s  = dphase_valid_r && HRESP && !HREADY;
        budget_s     = BUD_W'(occupancy_s) + BUD_W'(addr_busy_s) + BUD_W'(dphase_valid_r) + BUD_W'(1'b1);
        can_issue_s  = !halt_r && !full_s && (budget_s <= BUD_W'(DEPTH));
        misaligned_s = (if_nxt_pc[1:0] != 2'b00);
        flush_adr_s  = {if_nxt_pc[PHYS_ADDR_SIZE-1:OFFS], {OFFS{1'b0}}};
        push_bus_s   = dphase_valid_r && HREADY && !dphase_stale_r;
    end

    // Next-state of the address/data pipeline; redirect overrides everything else.
    always_comb begin
        htrans_n       = htrans_r;
        haddr_n        = haddr_r;
        fetch_adr_n    = fetch_adr_r;
        need_nonseq_n  = need_nonseq_r;
        addr_stale_n   = addr_stale_r;
        dphase_valid_n = dphase_valid_r;
        dphase_pc_n    = dphase_pc_r;
        dphase_stale_n = dphase_stale_r;
        halt_n         = halt_r;
        mis_pend_n     = 1'b0;
        mis_pc_n       = mis_pc_r;
        if (HREADY) begin
            dphase_valid_n = addr_busy_s;
            dphase_pc_n    = XLEN'(haddr_r);
            dphase_stale_n = addr_stale_r;
            addr_stale_n   = 1'b0;
            if (can_issue_s) begin
                htrans_n      = (need_nonseq_r || at_1k_boundary(fetch_adr_r[9:0])) ? HTRANS_NONSEQ : HTRANS_SEQ;
                haddr_n       = fetch_adr_r;
                fetch_adr_n   = fetch_adr_r + PHYS_ADDR_SIZE'(XLEN/8);
                need_nonseq_n = 1'b0;
            end else begin
                htrans_n      = HTRANS_IDLE;
                need_nonseq_n = 1'b1;
            end
        end else if (err_first_s) begin
            // The pending address phase is abandoned; rewind so a live one is refetched.
            htrans_n      = HTRANS_IDLE;
            need_nonseq_n = 1'b1;
            addr_stale_n  = 1'b0;
            if (addr_busy_s && !addr_stale_r) begin
                fetch_adr_n = haddr_r;
            end else begin
                fetch_adr_n = fetch_adr_r;
            end
            if (!dphase_stale_r) begin
                halt_n = 1'b1;
            end else begin
                halt_n = halt_r;
            end
        end else begin
            htrans_n = htrans_r;
        end
        if (if_flush) begin
            fetch_adr_n    = flush_adr_s;
            need_nonseq_n  = 1'b1;
            halt_n         = misaligned_s;
            mis_pend_n     = misaligned_s;
            mis_pc_n       = if_nxt_pc;
            dphase_stale_n = 1'b1;
            if (HREADY) begin
                htrans_n = HTRANS_IDLE;
            end else begin
                htrans_n = htrans_n;
            end
            addr_stale_n = (htrans_n != HTRANS_IDLE);
        end else begin
            mis_pc_n = mis_pc_r;
        end
    end

    // Pipeline state registers.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            htrans_r       <= HTRANS_IDLE;
            haddr_r        <= {PHYS_ADDR_SIZE{1'b0}};
            fetch_adr_r    <= PHYS_ADDR_SIZE'(PC_INIT);
            need_nonseq_r  <= 1'b1;
            addr_stale_r   <= 1'b0;
            dphase_valid_r <= 1'b0;
            dphase_pc_r    <= {XLEN{1'b0}};
            dphase_stale_r <= 1'b0;
            halt_r         <= 1'b0;
            mis_pend_r     <= 1'b0;
            mis_pc_r       <= {XLEN{1'b0}};
        end else begin
            htrans_r       <= htrans_n;
            haddr_r        <= haddr_n;
            fetch_adr_r    <= fetch_adr_n;
            need_nonseq_r  <= need_nonseq_n;
            addr_stale_r   <= addr_stale_n;
            dphase_valid_r <= dphase_valid_n;
            dphase_pc_r    <= dphase_pc_n;
            dphase_stale_r <= dphase_stale_n;
            halt_r         <= halt_n;
            mis_pend_r     <= mis_pend_n;
            mis_pc_r       <= mis_pc_n;
        end
    end

    // Entry source: live bus completion, otherwise the deferred misaligned marker.
    always_comb begin
        if (push_bus_s) begin
            push_data_s = {HRDATA[PARCEL_SIZE-1:0], dphase_pc_r, 1'b0, HRESP};
        end else begin
            push_data_s = {{PARCEL_SIZE{1'b0}}, mis_pc_r, 1'b1, 1'b0};
        end
    end

    riscv_iprefetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (HCLK),
        .rst_n     (HRESETn),
        .clear     (if_flush),
        .push      (push_bus_s || mis_pend_r),
        .pop       (pop_s),
        .push_data (push_data_s),
        .pop_data  (head_s),
        .full      (full_s),
        .empty     (empty_s),
        .occupancy (occupancy_s)
    );

    assign pop_s                = if_parcel_valid && !if_stall;
    assign if_parcel_valid      = !empty_s && !if_flush;
    assign if_stall_nxt_pc      = !if_parcel_valid;
    assign if_parcel            = head_s[ENTRY_W-1 -: PARCEL_SIZE];
    assign if_parcel_pc         = head_s[XLEN+1:2];
    assign if_parcel_misaligned = !empty_s && head_s[1];
    assign if_parcel_error      = !empty_s && head_s[0];

    // The first error cycle must already show IDLE on the bus.
    assign htrans_s  = err_first_s ? HTRANS_IDLE : htrans_r;
    assign HTRANS    = htrans_s;
    assign HSEL      = (htrans_s != HTRANS_IDLE);
    assign HADDR     = haddr_r;
    assign HWDATA    = {XLEN{1'b0}};
    assign HWRITE    = 1'b0;
    assign HMASTLOCK = 1'b0;
    assign HBURST    = HBURST_INCR;
    assign HSIZE     = (XLEN == 64) ? HSIZE_DWORD : HSIZE_WORD;
    assign HPROT     = {2'b00, (st_prv != 2'b00), 1'b0};

endmodule

// File: tb/tb_riscv_iprefetch_ahb3lite.sv
// Directed bench for the prefetcher: a simple zero-wait slave whose read data is addr ^ 'hCAFE0000.
module tb_riscv_iprefetch_ahb3lite;

    logic        HCLK, HRESETn, HSEL, HWRITE, HMASTLOCK, HREADY, HRESP;
    logic [31:0] HADDR, HRDATA, HWDATA;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;
    logic [1:0]  HTRANS, st_prv;
    logic [31:0] if_nxt_pc, if_parcel, if_parcel_pc;
    logic        if_flush, if_stall, if_parcel_valid, if_parcel_misaligned, if_parcel_error, if_stall_nxt_pc;
    logic [31:0] dp_addr;
    int          n_checks, n_fail;

    riscv_iprefetch_ahb3lite dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HRDATA(HRDATA),
        .HWDATA(HWDATA), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
        .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK), .HREADY(HREADY), .HRESP(HRESP),
        .if_nxt_pc(if_nxt_pc), .if_flush(if_flush), .if_stall(if_stall), .st_prv(st_prv),
        .if_parcel(if_parcel), .if_parcel_pc(if_parcel_pc), .if_parcel_valid(if_parcel_valid),
        .if_parcel_misaligned(if_parcel_misaligned), .if_parcel_error(if_parcel_error),
        .if_stall_nxt_pc(if_stall_nxt_pc)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // Slave: latch the accepted address, return its data in the data phase.
    always @(posedge HCLK) begin
        if (HREADY && HTRANS != 2'b00) dp_addr <= HADDR;
    end
    assign HRDATA = dp_addr ^ 32'hCAFE_0000;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_bus(input string tag, input logic [31:0] addr, input logic [1:0] trans);
        int n = 0;
        while (!(HTRANS == trans && HADDR == addr) && n < 30) begin
            @(negedge HCLK);
            n++;
        end
        check_eq(tag, (HTRANS == trans && HADDR == addr), 1'b1);
    endtask

    task automatic take(input string tag, input logic [31:0] pc, input logic err, input logic mis);
        int n = 0;
        while (!if_parcel_valid && n < 20) begin
            @(negedge HCLK);
            n++;
        end
        check_eq({tag, "_valid"}, if_parcel_valid, 1'b1);
        check_eq({tag, "_pc"}, if_parcel_pc, pc);
        check_eq({tag, "_err"}, if_parcel_error, err);
        check_eq({tag, "_mis"}, if_parcel_misaligned, mis);
        if (!err && !mis) check_eq({tag, "_data"}, if_parcel, pc ^ 32'hCAFE_0000);
        if_stall = 1'b0;
        @(negedge HCLK);
        if_stall = 1'b1;
    endtask

    task automatic flush_to(input logic [31:0] pc);
        if_flush  = 1'b1;
        if_nxt_pc = pc;
        #1;
        check_eq("flush_masks_valid", if_parcel_valid, 1'b0);
        @(negedge HCLK);
        if_flush = 1'b0;
    endtask

    task automatic count_idle(input string tag, input int cycles);
        int busy = 0;
        for (int i = 0; i < cycles; i++) begin
            if (HTRANS != 2'b00) busy++;
            @(negedge HCLK);
        end
        check_eq(tag, 32'(busy), 32'd0);
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        HRESETn = 1'b0; HREADY = 1'b1; HRESP = 1'b0; if_flush = 1'b0;
        if_nxt_pc = 32'h0; if_stall = 1'b1; st_prv = 2'b11;
        repeat (2) @(negedge HCLK);
        check_eq("rst_htrans", HTRANS, 2'b00);
        check_eq("rst_hsel", HSEL, 1'b0);
        check_eq("rst_haddr", HADDR, 32'h0);
        check_eq("rst_valid", if_parcel_valid, 1'b0);
        check_eq("rst_err", if_parcel_error, 1'b0);
        check_eq("rst_mis", if_parcel_misaligned, 1'b0);
        check_eq("rst_stall_nxt", if_stall_nxt_pc, 1'b1);

        // Fill four entries with the consumer stalled.
        HRESETn = 1'b1;
        @(negedge HCLK);
        check_eq("t1_first", {HTRANS, HADDR}, {2'b10, 32'h200});
        check_eq("t1_hsel", HSEL, 1'b1);
        check_eq("t1_consts", {HSIZE, HBURST, HWRITE, HMASTLOCK, HPROT}, {3'b010, 3'b001, 1'b0, 1'b0, 4'b0010});
        check_eq("t1_hwdata", HWDATA, 32'h0);
        for (int i = 1; i < 4; i++) begin
            @(negedge HCLK);
            check_eq("t1_seq", {HTRANS, HADDR}, {2'b11, 32'h200 + 32'(4 * i)});
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge HCLK);
            check_eq("t1_idle", {HTRANS, HSEL}, {2'b00, 1'b0});
        end
        check_eq("t1_head_pc", if_parcel_pc, 32'h200);
        check_eq("t1_stall_nxt", if_stall_nxt_pc, 1'b0);
        st_prv = 2'b00;
        #1 check_eq("t1_hprot_user", HPROT, 4'b0000);
        st_prv = 2'b11;
        for (int i = 0; i < 6; i++) take("t1_take", 32'h200 + 32'(4 * i), 1'b0, 1'b0);
        repeat (10) @(negedge HCLK);

        // 1 KB boundary restarts the burst.
        flush_to(32'h3F8);
        wait_bus("t2_3f8", 32'h3F8, 2'b10);
        @(negedge HCLK) check_eq("t2_3fc", {HTRANS, HADDR}, {2'b11, 32'h3FC});
        @(negedge HCLK) check_eq("t2_400", {HTRANS, HADDR}, {2'b10, 32'h400});
        @(negedge HCLK) check_eq("t2_404", {HTRANS, HADDR}, {2'b11, 32'h404});
        take("t2_p0", 32'h3F8, 1'b0, 1'b0);
        take("t2_p1", 32'h3FC, 1'b0, 1'b0);
        take("t2_p2", 32'h400, 1'b0, 1'b0);
        repeat (10) @(negedge HCLK);

        // Redirect while the 0x20C data phase is waiting: that data must be dropped.
        flush_to(32'h200);
        wait_bus("t3_20c", 32'h20C, 2'b11);
        @(negedge HCLK) check_eq("t3_idle", HTRANS, 2'b00);
        HREADY = 1'b0; if_flush = 1'b1; if_nxt_pc = 32'h1000;
        @(negedge HCLK);
        if_flush = 1'b0; HREADY = 1'b1;
        check_eq("t3_cleared", if_parcel_valid, 1'b0);
        take("t3_p0", 32'h1000, 1'b0, 1'b0);
        take("t3_p1", 32'h1004, 1'b0, 1'b0);
        repeat (10) @(negedge HCLK);

        // Bus error on 0x208.
        flush_to(32'h200);
        wait_bus("t4_20c", 32'h20C, 2'b11);
        HRESP = 1'b1; HREADY = 1'b0;
        #1 check_eq("t4_err_idle", {HTRANS, HSEL}, {2'b00, 1'b0});
        @(negedge HCLK);
        HREADY = 1'b1;
        #1 check_eq("t4_err2_idle", HTRANS, 2'b00);
        @(negedge HCLK);
        HRESP = 1'b0;
        count_idle("t4_halted", 8);
        take("t4_p0", 32'h200, 1'b0, 1'b0);
        take("t4_p1", 32'h204, 1'b0, 1'b0);
        take("t4_p2", 32'h208, 1'b1, 1'b0);
        count_idle("t4_still_halted", 5);
        check_eq("t4_empty", if_parcel_valid, 1'b0);

        // Misaligned redirect target.
        flush_to(32'h1002);
        count_idle("t5_no_bus", 6);
        take("t5_mis", 32'h1002, 1'b0, 1'b1);
        count_idle("t5_halted", 4);
        check_eq("t5_single", if_parcel_valid, 1'b0);

        // Wait states on the 0x204 data phase.
        flush_to(32'h200);
        wait_bus("t6_208", 32'h208, 2'b11);
        HREADY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 check_eq("t6_hold", {HTRANS, HADDR}, {2'b11, 32'h208});
            @(negedge HCLK);
        end
        HREADY = 1'b1;
        for (int i = 0; i < 4; i++) take("t6_take", 32'h200 + 32'(4 * i), 1'b0, 1'b0);

        // Reset in the middle of fetching.
        HRESETn = 1'b0;
        #1 check_eq("t7_rst", {HTRANS, HSEL, HADDR, if_parcel_valid}, {2'b00, 1'b0, 32'h0, 1'b0});
        @(negedge HCLK);
        HRESETn = 1'b1;
        @(negedge HCLK) check_eq("t7_restart", {HTRANS, HADDR}, {2'b10, 32'h200});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/riscv_iprefetch_ahb3lite.md
RISCV_IPREFETCH_AHB3LITE -- requirements
Module: riscv_iprefetch_ahb3lite

Interface
REQ-001 SHALL have parameters: XLEN 32 (bus/data width, 32|64); PHYS_ADDR_SIZE XLEN (HADDR width); PARCEL_SIZE XLEN (parcel width); DEPTH 4 (buffer entries, power of 2, >=2); PC_INIT 'h200 (fetch address after reset).
REQ-002 SHALL have one clock and an asynchronous active-low reset: HCLK input 1 (clock, rising edge); HRESETn input 1 (async reset, active low).
REQ-003 SHALL have AHB3-Lite master ports: HSEL out 1; HADDR out PHYS_ADDR_SIZE; HRDATA in XLEN; HWDATA out XLEN; HWRITE out 1; HSIZE out 3; HBURST out 3; HPROT out 4; HTRANS out 2; HMASTLOCK out 1; HREADY in 1; HRESP in 1.
REQ-004 SHALL have CPU-side ports: if_nxt_pc in XLEN (redirect target); if_flush in 1 (redirect strobe); if_stall in 1 (consumer stall); st_prv in 2 (privilege level); if_parcel out PARCEL_SIZE; if_parcel_pc out XLEN; if_parcel_valid out 1; if_parcel_misaligned out 1; if_parcel_error out 1; if_stall_nxt_pc out 1.

Function
REQ-005 SHALL fetch word-aligned (XLEN/8 bytes) sequential addresses from fetch_adr into a DEPTH-entry FIFO of {data, pc, misaligned, error}.
REQ-006 SHALL drive constants: HWRITE=0, HWDATA=0, HMASTLOCK=0, HBURST=INCR (3'b001), HSIZE=3'b010 (XLEN=32) / 3'b011 (XLEN=64), HPROT={2'b00, st_prv!=0, 1'b0}.
REQ-007 SHALL drive HSEL=1 exactly when HTRANS!=IDLE.
REQ-008 SHALL start a new address phase only when occupancy + in-flight transfers (address and data phases) + 1 <= DEPTH; otherwise HTRANS=IDLE.
REQ-009 SHALL use HTRANS=NONSEQ for the first transfer after reset, an IDLE cycle, a redirect, or when HADDR crosses a 1 KB boundary; SEQ otherwise.
REQ-010 SHALL hold HADDR/HTRANS stable while HREADY=0 during a pending address phase.
REQ-011 SHALL push HRDATA with its pc into the FIFO on the data-phase cycle with HREADY=1, HRESP=0.
REQ-012 SHALL, on HRESP=1 with HREADY=0 (first error cycle), drive HTRANS=IDLE in that cycle, then on completion push one entry with error=1 and halt fetching until the next if_flush.
REQ-013 SHALL present the FIFO head on if_parcel/if_parcel_pc/flags, with if_parcel_valid = not empty and not if_flush; pop when if_parcel_valid=1 and if_stall=0.
REQ-014 SHALL drive if_stall_nxt_pc = not if_parcel_valid.
REQ-015 SHALL, on if_flush=1: empty the FIFO at the next edge, set fetch_adr = if_nxt_pc aligned down, and mark every in-flight transfer stale; stale data is discarded on completion and counts as in-flight until then.
REQ-016 SHALL, on if_flush with if_nxt_pc[1:0]!=0, issue no bus transfer, push one entry with misaligned=1, pc=if_nxt_pc, and halt until the next if_flush.
REQ-017 SHALL give if_flush priority over a simultaneous push or pop in the same cycle.
REQ-018 SHALL make data completing at cycle t visible on if_parcel at t+1 (1-cycle push-to-valid latency).
REQ-019 SHALL wrap fetch_adr modulo 2^PHYS_ADDR_SIZE with no error.
REQ-020 SHALL never push when full (guaranteed by REQ-008); a pop and a push in the same cycle keep occupancy unchanged.

Reset
REQ-021 SHALL, with HRESETn low, asynchronously set: FIFO empty, HTRANS=IDLE, HSEL=0, HADDR=0, if_parcel_valid=0, if_parcel_error=0, if_parcel_misaligned=0, halt=0, fetch_adr=PC_INIT.
REQ-022 SHALL issue NONSEQ to PC_INIT in the first cycle after HRESETn deasserts; reset asserted mid-transfer abandons the transfer.

Structure
REQ-023 SHALL take HTRANS, HBURST and HSIZE encodings from the shared biu_constants_pkg; no local redefinition.
REQ-024 SHALL implement the buffer as sub-module riscv_iprefetch_fifo (parameters DEPTH, WIDTH; push/pop/clear, full/empty, occupancy).

Verification
REQ-025 Reset release, HREADY=1, DEPTH=4, if_stall=1 -> NONSEQ 'h200, SEQ 'h204/'h208/'h20C, then IDLE; four entries buffered.
REQ-026 Fetch at 'h3F8 -> HADDR 'h3FC SEQ, 'h400 NONSEQ.
REQ-027 if_flush with if_nxt_pc='h1000 while 'h20C data phase pending -> 'h20C data dropped, next valid parcel pc='h1000, no stale parcel delivered.
REQ-028 HRESP=1 on 'h208 -> HTRANS=IDLE in first error cycle; entry 'h208 delivered with if_parcel_error=1; no further HTRANS until if_flush.
REQ-029 if_flush with if_nxt_pc='h1002 -> no HTRANS activity; one parcel, if_parcel_misaligned=1, pc='h1002.
REQ-030 HREADY held 0 for 3 cycles on 'h204 -> HADDR/HTRANS unchanged; parcel order 'h200, 'h204, 'h208 preserved.
